// File: rtl/bus_pkg.sv
// Shared bus definitions for the CPU-side memory fabric.
//   arb_state_t          : arbiter FSM states (IDLE, BUSY)
//   OWNER_IBUS/OWNER_DBUS: grant owner encodings
//   BUS_AW/BUS_DW        : address and data widths of the CPU buses
package bus_pkg;
   localparam int   BUS_AW     = 32;
   localparam int   BUS_DW     = 32;
   localparam logic OWNER_IBUS = 1'b0;
   localparam logic OWNER_DBUS = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;
endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM slave port between the instruction bus
// (read-only) and the data bus. Round-robin grant, held until the slave
// completes; a watchdog ends hung accesses with an error response.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ibus_req/addr               fetch request in; ibus_rdata/ready/error out
//   dbus_req/we/addr/wdata/wstrb data request in; dbus_rdata/ready/error out
//   mem_req/we/addr/wdata/wstrb registered slave command out
//   mem_rdata/ready/error       slave response in
//   busy, owner, timeout        status: in BUSY, current/last grant, watchdog pulse
module ram_port_arbiter
   import bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ibus_req,
   input  logic [BUS_AW-1:0] ibus_addr,
   output logic [BUS_DW-1:0] ibus_rdata,
   output logic              ibus_ready,
   output logic              ibus_error,
   input  logic              dbus_req,
   input  logic              dbus_we,
   input  logic [BUS_AW-1:0] dbus_addr,
   input  logic [BUS_DW-1:0] dbus_wdata,
   input  logic [3:0]        dbus_wstrb,
   output logic [BUS_DW-1:0] dbus_rdata,
   output logic              dbus_ready,
   output logic              dbus_error,
   output logic              mem_req,
   output logic              mem_we,
   output logic [BUS_AW-1:0] mem_addr,
   output logic [BUS_DW-1:0] mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [BUS_DW-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic              mem_error,
   output logic              busy,
   output logic              owner,
   output logic              timeout
);

   localparam int            CW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   arb_state_t        state_q, state_d;
   logic              owner_q;
   logic              cmd_we_q;
   logic [BUS_AW-1:0] cmd_addr_q;
   logic [BUS_DW-1:0] cmd_wdata_q;
   logic [3:0]        cmd_wstrb_q;
   logic [CW-1:0]     cnt_q;

   logic              grant_v, grant_dbus, done, fire;
   logic [BUS_DW-1:0] resp_rdata;
   logic              resp_err;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      grant_v    = 1'b0;
      grant_dbus = 1'b0;
      done       = 1'b0;
      fire       = 1'b0;
      case (state_q)
         IDLE: begin
            if (ibus_req || dbus_req) begin
               grant_v = 1'b1;
               // on a tie, the master that did not hold the last grant wins
               grant_dbus = (ibus_req && dbus_req) ? ~owner_q : dbus_req;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            // a real completion always beats the watchdog in the same cycle
            if (mem_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               done    = 1'b1;
               fire    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q     <= OWNER_IBUS;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_wstrb_q <= '0;
         cnt_q       <= '0;
      end else if (grant_v) begin
         owner_q <= grant_dbus;
         cnt_q   <= '0;
         if (grant_dbus) begin
            cmd_we_q    <= dbus_we;
            cmd_addr_q  <= dbus_addr;
            cmd_wdata_q <= dbus_wdata;
            cmd_wstrb_q <= dbus_wstrb;
         end else begin
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= ibus_addr;
            cmd_wdata_q <= '0;
            cmd_wstrb_q <= 4'hF;
         end
      end else if (state_q == BUSY && !mem_ready && cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // a watchdog completion returns zero data with error set
   assign resp_rdata = mem_ready ? mem_rdata : '0;
   assign resp_err   = mem_ready ? mem_error : 1'b1;

   assign ibus_ready = done && (owner_q == OWNER_IBUS);
   assign dbus_ready = done && (owner_q == OWNER_DBUS);
   assign ibus_rdata = ibus_ready ? resp_rdata : '0;
   assign dbus_rdata = dbus_ready ? resp_rdata : '0;
   assign ibus_error = ibus_ready && resp_err;
   assign dbus_error = dbus_ready && resp_err;

   assign mem_req   = (state_q == BUSY);
   assign mem_we    = cmd_we_q;
   assign mem_addr  = cmd_addr_q;
   assign mem_wdata = cmd_wdata_q;
   assign mem_wstrb = cmd_wstrb_q;
   assign busy      = (state_q == BUSY);
   assign owner     = owner_q;
   assign timeout   = fire;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic [31:0] ibus_rdata;
   logic        ibus_ready, ibus_error;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic [3:0]  dbus_wstrb;
   logic [31:0] dbus_rdata;
   logic        dbus_ready, dbus_error;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready, mem_error;
   logic        busy, owner, timeout;

   ram_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_rdata(ibus_rdata),
      .ibus_ready(ibus_ready), .ibus_error(ibus_error),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb), .dbus_rdata(dbus_rdata),
      .dbus_ready(dbus_ready), .dbus_error(dbus_error),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .mem_error(mem_error),
      .busy(busy), .owner(owner), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // transaction-level reference: one pending access and how long it has waited
   typedef struct {
      bit          active;
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          waited;
   } xact_t;
   xact_t cur;
   bit    last_d;   // who held the most recent grant

   // snapshot of outputs seen at the last sampling point
   logic s_ir, s_dr, s_ie, s_de, s_to, s_mreq, s_busy, s_own, s_mwe;
   logic [31:0] s_ird, s_drd, s_maddr, s_mwd;
   logic [3:0]  s_mws;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cur    = '{active: 0, is_d: 0, we: 0, addr: 0, wdata: 0, wstrb: 0, waited: 0};
      last_d = 0;
   endtask

   // one clock: compare at negedge against the model, advance model at posedge
   task automatic step();
      bit          fin_ok, fin_to;
      logic [31:0] e_rd;
      logic        e_er;
      @(negedge clk);
      fin_ok = cur.active && mem_ready;
      fin_to = cur.active && !mem_ready && (cur.waited == T - 1);
      e_rd   = fin_ok ? mem_rdata : 32'h0;
      e_er   = fin_ok ? mem_error : 1'b1;
      {s_ir, s_dr, s_ie, s_de, s_to} = {ibus_ready, dbus_ready, ibus_error, dbus_error, timeout};
      {s_ird, s_drd, s_mreq, s_busy, s_own} = {ibus_rdata, dbus_rdata, mem_req, busy, owner};
      {s_mwe, s_maddr, s_mwd, s_mws} = {mem_we, mem_addr, mem_wdata, mem_wstrb};
      chk("ibus_ready", ibus_ready, (fin_ok || fin_to) && !cur.is_d);
      chk("dbus_ready", dbus_ready, (fin_ok || fin_to) && cur.is_d);
      chk("ibus_rdata", ibus_rdata, ((fin_ok || fin_to) && !cur.is_d) ? e_rd : 32'h0);
      chk("dbus_rdata", dbus_rdata, ((fin_ok || fin_to) && cur.is_d) ? e_rd : 32'h0);
      chk("ibus_error", ibus_error, ((fin_ok || fin_to) && !cur.is_d) ? e_er : 1'b0);
      chk("dbus_error", dbus_error, ((fin_ok || fin_to) && cur.is_d) ? e_er : 1'b0);
      chk("timeout", timeout, fin_to);
      chk("mem_req", mem_req, cur.active);
      chk("busy", busy, cur.active);
      chk("owner", owner, last_d);
      chk("mem_we", mem_we, cur.we);
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_wdata", mem_wdata, cur.wdata);
      chk("mem_wstrb", mem_wstrb, cur.wstrb);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (cur.active) begin
         if (fin_ok || fin_to) cur.active = 0;
         else                  cur.waited++;
      end else if (ibus_req || dbus_req) begin
         cur.is_d   = (ibus_req && dbus_req) ? !last_d : dbus_req;
         last_d     = cur.is_d;
         cur.active = 1;
         cur.waited = 0;
         if (cur.is_d) begin
            cur.we = dbus_we; cur.addr = dbus_addr; cur.wdata = dbus_wdata; cur.wstrb = dbus_wstrb;
         end else begin
            cur.we = 0; cur.addr = ibus_addr; cur.wdata = 0; cur.wstrb = 4'hF;
         end
      end
      #1;
   endtask

   initial begin
      bit order[$];
      rst = 1; ibus_req = 0; ibus_addr = 0; dbus_req = 0; dbus_we = 0;
      dbus_addr = 0; dbus_wdata = 0; dbus_wstrb = 0;
      mem_rdata = 0; mem_ready = 0; mem_error = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      step();   // reset state checked against the cleared model
      chk("rst_busy", s_busy, 1'b0);
      chk("rst_owner", s_own, 1'b0);
      rst = 0;

      // single fetch, zero-wait slave
      ibus_req = 1; ibus_addr = 32'h100; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
      step();
      chk("f_idle_ready", s_ir, 1'b0);
      step();
      chk("f_ready", s_ir, 1'b1);
      chk("f_rdata", s_ird, 32'hDEADBEEF);
      chk("f_we", s_mwe, 1'b0);
      chk("f_wstrb", s_mws, 4'hF);
      ibus_req = 0;
      step();
      chk("f_back_idle", s_busy, 1'b0);

      // tie from owner=0: dbus first, then alternating
      ibus_req = 1; dbus_req = 1; ibus_addr = 32'h40; dbus_addr = 32'h80;
      for (int i = 0; i < 20 && order.size() < 4; i++) begin
         step();
         if (s_dr) order.push_back(1'b1);
         if (s_ir) order.push_back(1'b0);
      end
      chk("alt_count", order.size(), 4);
      if (order.size() == 4) begin
         chk("alt0", order[0], 1'b1);
         chk("alt1", order[1], 1'b0);
         chk("alt2", order[2], 1'b1);
         chk("alt3", order[3], 1'b0);
      end
      ibus_req = 0; dbus_req = 0;
      step();

      // stalled write: command stable for 4 cycles, ready on the 4th
      dbus_req = 1; dbus_we = 1; dbus_addr = 32'h2000; dbus_wdata = 32'h12345678;
      dbus_wstrb = 4'b0011; mem_ready = 0;
      step();
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         dbus_addr = 32'hBAD0 + k;   // mid-access changes must be ignored
         step();
         chk("w_addr", s_maddr, 32'h2000);
         chk("w_wdata", s_mwd, 32'h12345678);
         chk("w_wstrb", s_mws, 4'b0011);
         chk("w_ready", s_dr, k == 3);
         chk("w_iready", s_ir, 1'b0);
      end
      dbus_req = 0; dbus_we = 0; mem_ready = 0;
      step();

      // slave never answers: watchdog fires on the T-th BUSY cycle
      dbus_req = 1; dbus_addr = 32'h3000;
      step();
      for (int k = 0; k < T; k++) begin
         step();
         chk("to_pulse", s_to, k == T - 1);
         chk("to_ready", s_dr, k == T - 1);
         chk("to_error", s_de, k == T - 1);
      end
      dbus_req = 0;
      step();
      chk("to_req_low", s_mreq, 1'b0);

      // completion with error at the limit beats the watchdog
      dbus_req = 1;
      step();
      for (int k = 0; k < T; k++) begin
         mem_ready = (k == T - 1); mem_error = (k == T - 1);
         step();
      end
      chk("lim_error", s_de, 1'b1);
      chk("lim_timeout", s_to, 1'b0);
      dbus_req = 0; mem_ready = 0; mem_error = 0;
      step();

      // reset mid-access
      dbus_req = 1;
      step();
      repeat (2) step();
      rst = 1;
      step();
      rst = 0; dbus_req = 0;
      step();
      chk("mr_req", s_mreq, 1'b0);
      chk("mr_busy", s_busy, 1'b0);
      chk("mr_owner", s_own, 1'b0);
      chk("mr_noready", s_dr, 1'b0);
      ibus_req = 1; ibus_addr = 32'h500; mem_ready = 1; mem_rdata = 32'hCAFE0001;
      step();
      step();
      chk("mr_regrant", s_ir, 1'b1);
      ibus_req = 0;
      step();

      // randomized traffic against the reference
      for (int c = 0; c < 3000; c++) begin
         if (!ibus_req && $urandom_range(2) == 0) ibus_req = 1;
         if (!dbus_req && $urandom_range(2) == 0) begin
            dbus_req = 1; dbus_we = $urandom_range(1); dbus_wstrb = 4'($urandom);
         end
         ibus_addr  = $urandom;
         dbus_addr  = $urandom;
         dbus_wdata = $urandom;
         mem_ready  = ($urandom_range(3) == 0);
         mem_error  = $urandom_range(1);
         mem_rdata  = $urandom;
         rst        = ($urandom_range(127) == 0);
         step();
         if (s_ir) ibus_req = 0;
         if (s_dr) dbus_req = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
